// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - state encoding and default sizing for sum_accumulator
// Shared by sum_accumulator and sum_acc_add.
package sum_acc_pkg;

  localparam int DEF_ACC_W   = 8;
  localparam int DEF_N_TERMS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } sum_acc_state_e;

endpackage

// File: rtl/sum_acc_add.sv
// rtl/sum_acc_add.sv - next-total adder with wrap or saturate (SUM_ACC_SAT_EN)
// Pure combinational; the overflow flag it returns is already sticky.
import sum_acc_pkg::*;

module sum_acc_add #(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] total,
  input  logic [4:0]       sum_in,
  input  logic             ovf,
  output logic [ACC_W-1:0] total_nxt,
  output logic             ovf_nxt
);

  logic [ACC_W:0] wide;

  // One extra bit catches the carry out of the accumulator width.
  assign wide    = {1'b0, total} + {{(ACC_W-4){1'b0}}, sum_in};
  assign ovf_nxt = ovf | wide[ACC_W];

`ifdef SUM_ACC_SAT_EN
  // Once the frame has overflowed the total is pinned at full scale.
  assign total_nxt = ovf_nxt ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
  assign total_nxt = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - frame accumulator of 5-bit sums (SUM_ACC_SAT_EN selects saturation)
// Accepts N_TERMS sums per frame, then holds the total until the consumer takes it.
import sum_acc_pkg::*;

module sum_accumulator #(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_TERMS = DEF_N_TERMS
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       SUM_IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             CLR,
  output logic [ACC_W-1:0] TOTAL,
  output logic             OVF,
  output logic [3:0]       COUNT,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam logic [3:0] LAST = 4'(N_TERMS);

  sum_acc_state_e   state;
  logic             xfer;
  logic             take;
  logic [3:0]       count_inc;
  logic [ACC_W-1:0] total_nxt;
  logic             ovf_nxt;

  // Handshake outputs decode the registered state only.
  assign IN_READY  = (state != HOLD);
  assign OUT_VALID = (state == HOLD);
  assign xfer      = IN_VALID & IN_READY;
  assign take      = OUT_VALID & OUT_READY;
  assign count_inc = COUNT + 4'd1;

  sum_acc_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .total    (TOTAL),
    .sum_in   (SUM_IN),
    .ovf      (OVF),
    .total_nxt(total_nxt),
    .ovf_nxt  (ovf_nxt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      TOTAL <= '0;
      OVF   <= 1'b0;
      COUNT <= '0;
    end else if (CLR || take) begin
      // Abort and frame delivery both restart from an empty frame.
      state <= IDLE;
      TOTAL <= '0;
      OVF   <= 1'b0;
      COUNT <= '0;
    end else if (xfer) begin
      TOTAL <= total_nxt;
      OVF   <= ovf_nxt;
      COUNT <= count_inc;
      state <= (count_inc == LAST) ? HOLD : ACCUM;
    end
  end

endmodule
